// File: rtl/usr_shift_sequencer.sv
// ----------------------------------------------------------------------------
// usr_shift_sequencer
//
// Command-driven sequencer for a 4-bit universal shift register.
// MODE: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
// It takes one command per valid/ready transaction. For each command it
// parallel-loads the operand, applies N shift cycles with a chosen fill bit,
// and then returns the final register value on a valid/ready response port.
//
// Optional feature macro: USR_SEQ_ROTATE_EN
//   defined   : op 11 rotates right; the fill is taken from sr_dataout[0].
//   undefined : op 11 is rejected with rsp_err=1. The register is not touched.
//
// Ports
//   clock, reset            clock; synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_op/data/count/fill  op code, operand, shift count, serial fill bit
//   rsp_valid/rsp_ready     response handshake
//   rsp_data/rsp_err        final register value / unsupported-op flag
//   busy                    high whenever the sequencer is not idle
//   sr_mode/sr_datain       drive the shift register MODE/DATAIN
//   sr_dataout              shift register DATAOUT
// ----------------------------------------------------------------------------
module usr_shift_sequencer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_fill,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic             busy,
   output logic [1:0]       sr_mode,
   output logic [WIDTH-1:0] sr_datain,
   input  logic [WIDTH-1:0] sr_dataout
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               fill_q, fill_d;
   logic               err_q, err_d;
   logic               accept;
   logic               op_ok;

`ifdef USR_SEQ_ROTATE_EN
   localparam bit RotateEn = 1'b1;
   assign op_ok = 1'b1;
`else
   localparam bit RotateEn = 1'b0;
   assign op_ok = (cmd_op != 2'b11);
`endif

   assign accept = cmd_valid & cmd_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         op_q    <= 2'b00;
         data_q  <= '0;
         cnt_q   <= '0;
         fill_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         err_q   <= err_d;
      end
   end

   // sr_* are decoded only from the registered state and the latched command.
   // The rotate fill comes from sr_dataout; no cmd_* input reaches sr_*.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      fill_d    = fill_q;
      err_d     = err_q;
      sr_mode   = 2'b00;
      sr_datain = '0;
      cmd_ready = (state_q == StIdle) && !reset;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               op_d    = cmd_op;
               data_d  = cmd_data;
               fill_d  = cmd_fill;
               // A load-only command never shifts, whatever count was sent.
               cnt_d   = (cmd_op == 2'b00) ? '0 : cmd_count;
               err_d   = !op_ok;
               state_d = op_ok ? StLoad : StDone;
            end
         end
         StLoad: begin
            sr_mode   = 2'b11;
            sr_datain = data_q;
            state_d   = (cnt_q == '0) ? StDone : StShift;
         end
         StShift: begin
            sr_mode = (op_q == 2'b10) ? 2'b10 : 2'b01;
            // A replicated fill bit serves either serial-in tap.
            if (RotateEn && (op_q == 2'b11)) begin
               sr_datain = {WIDTH{sr_dataout[0]}};
            end else begin
               sr_datain = {WIDTH{fill_q}};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy      = (state_q != StIdle);
   assign rsp_valid = (state_q == StDone);
   assign rsp_err   = rsp_valid & err_q;
   assign rsp_data  = (rsp_valid && !err_q) ? sr_dataout : '0;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// ----------------------------------------------------------------------------
// tb_usr_shift_sequencer
// Directed bench for usr_shift_sequencer. A behavioural 4-bit universal shift
// register is connected to sr_mode/sr_datain/sr_dataout. Expected data,
// latency and sr_mode traces are worked out by hand for each vector.
// ----------------------------------------------------------------------------
module tb_usr_shift_sequencer;

   localparam int unsigned W = 4;
   localparam int unsigned C = 3;

   logic         clock = 1'b0;
   logic         reset;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_data;
   logic [C-1:0] cmd_count;
   logic         cmd_fill;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_err;
   logic         busy;
   logic [1:0]   sr_mode;
   logic [W-1:0] sr_datain;
   logic [W-1:0] sr_dataout;
   logic [W-1:0] sr_q = '0;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clock = ~clock;

   usr_shift_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .cmd_count  (cmd_count),
      .cmd_fill   (cmd_fill),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .sr_mode    (sr_mode),
      .sr_datain  (sr_datain),
      .sr_dataout (sr_dataout)
   );

   // Universal shift register: right = toward bit 0 with serial-in at the MSB,
   // left = toward the MSB with serial-in at bit 0.
   always @(posedge clock) begin
      case (sr_mode)
         2'b01:   sr_q <= {sr_datain[W-1], sr_q[W-1:1]};
         2'b10:   sr_q <= {sr_q[W-2:0], sr_datain[0]};
         2'b11:   sr_q <= sr_datain;
         default: sr_q <= sr_q;
      endcase
   end
   assign sr_dataout = sr_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Send one command, then sample each cycle at the negedge until rsp_valid.
   // Sample 1 is the cycle right after the accept edge.
   // Expected latency: N+2 samples for a supported op, 1 sample for a rejected op.
   // The trace packs sr_mode from every sample, oldest sample in the upper bits.
   // 'hold' keeps rsp_ready low for that many extra cycles before the handshake.
   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [W-1:0] data,
                          input logic [C-1:0] count, input logic fill,
                          input logic [W-1:0] exp_data, input logic exp_err,
                          input int exp_lat, input logic [31:0] exp_trace, input int hold);
      int          lat;
      logic [31:0] trace;
      lat   = 0;
      trace = '0;
      @(negedge clock);
      check({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = count;
      cmd_fill  = fill;
      @(posedge clock);
      #1 cmd_valid = 1'b0;
      do begin
         @(negedge clock);
         lat++;
         trace = {trace[29:0], sr_mode};
      end while (!rsp_valid && lat < 20);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_modes"}, trace, exp_trace);
      check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
      check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         check({tag, "_bp_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, "_bp_data"}, 32'(rsp_data), 32'(exp_data));
         check({tag, "_bp_mode"}, 32'(sr_mode), 32'd0);
         check({tag, "_bp_rdy"}, 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clock);
      #1 rsp_ready = 1'b0;
      @(negedge clock);
      check({tag, "_vdrop"}, 32'(rsp_valid), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = '0;
      cmd_count = '0;
      cmd_fill  = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_data", 32'(rsp_data), 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
      check("rst_mode", 32'(sr_mode), 32'd0);
      check("rst_din", 32'(sr_datain), 32'd0);
      check("rst_rdy", 32'(cmd_ready), 32'd0);
      reset = 1'b0;

      // Load-only: modes 11,00
      run_cmd("op00", 2'b00, 4'b1010, 3'd0, 1'b0, 4'b1010, 1'b0, 2, 32'hC, 0);
      // Load-only ignores count and fill
      run_cmd("op00_cnt", 2'b00, 4'b0110, 3'd7, 1'b1, 4'b0110, 1'b0, 2, 32'hC, 0);
      // 1011 >> 2 with fill 0: 0101, 0010; modes 11,01,01,00
      run_cmd("op01", 2'b01, 4'b1011, 3'd2, 1'b0, 4'b0010, 1'b0, 4, 32'hD4, 0);
      // 0111 << 1 with fill 1 -> 1111; modes 11,10,00
      run_cmd("op10", 2'b10, 4'b0111, 3'd1, 1'b1, 4'b1111, 1'b0, 3, 32'h38, 0);
      // Max count: 0001 << 7 with fill 0 -> 0000; modes 11,(10 x7),00
      run_cmd("op10_max", 2'b10, 4'b0001, 3'd7, 1'b0, 4'b0000, 1'b0, 9, 32'h3AAA8, 0);
      // Backpressure: 1100 >> 1 with fill 1 -> 1110; rsp_ready held low for 5 cycles
      run_cmd("bp", 2'b01, 4'b1100, 3'd1, 1'b1, 4'b1110, 1'b0, 3, 32'h34, 5);

      // Reset pulsed during SHIFT of op01 count=5
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_data  = 4'b1001;
      cmd_count = 3'd5;
      cmd_fill  = 1'b0;
      @(posedge clock);
      #1 cmd_valid = 1'b0;
      repeat (3) @(negedge clock);
      check("mid_mode", 32'(sr_mode), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_valid", 32'(rsp_valid), 32'd0);
      check("mid_srmode", 32'(sr_mode), 32'd0);
      check("mid_rdy_rst", 32'(cmd_ready), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("mid_rdy", 32'(cmd_ready), 32'd1);
      check("mid_valid2", 32'(rsp_valid), 32'd0);
      run_cmd("post_rst", 2'b00, 4'b0101, 3'd0, 1'b0, 4'b0101, 1'b0, 2, 32'hC, 0);

`ifdef USR_SEQ_ROTATE_EN
      // 0011 rotated right once -> 1001; four times -> 0011
      run_cmd("rot1", 2'b11, 4'b0011, 3'd1, 1'b0, 4'b1001, 1'b0, 3, 32'h34, 0);
      run_cmd("rot4", 2'b11, 4'b0011, 3'd4, 1'b1, 4'b0011, 1'b0, 6, 32'hD54, 0);
`else
      // Rejected: straight to DONE, sr_mode stays 00, register keeps 0101
      run_cmd("op11_err", 2'b11, 4'b0011, 3'd1, 1'b0, 4'b0000, 1'b1, 1, 32'h0, 0);
      check("op11_reg", 32'(sr_q), 32'h5);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
